// File: rtl/alu_pkg.sv
// Shared constants for the nibble-serial ALU add/sub path: FSM encoding,
// slice width and operation codes.
package alu_pkg;

   localparam int NIBBLE_W = 4;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder, the building block of the nibble add/sub stage.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/nibble_addsub_stage.sv
// Combinational 4-bit ripple add/sub slice. The carry-in is kept separate
// from sub so the controller can chain the carry across clock cycles.
module nibble_addsub_stage
   import alu_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                sub,
   input  logic                cin,
   output logic [NIBBLE_W-1:0] s,
   output logic                c3,
   output logic                c4
);

   logic [NIBBLE_W:0]   c;
   logic [NIBBLE_W-1:0] b_eff;

   assign c[0]  = cin;
   assign b_eff = b ^ {NIBBLE_W{sub}};

   for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
      full_adder u_fa (
         .a  (a[i]),
         .b  (b_eff[i]),
         .ci (c[i]),
         .s  (s[i]),
         .co (c[i+1])
      );
   end

   // c3 is the carry into the sign bit; with c4 it yields signed overflow.
   assign c3 = c[NIBBLE_W-1];
   assign c4 = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_addsub_seq.sv
// Multi-cycle two's-complement add/sub: one shared 4-bit slice is sequenced
// LSB nibble first, with the carry held in a register between cycles.
module nibble_serial_addsub_seq
   import alu_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                         Clock,
   input  logic                         Reset,
   input  logic                         Start,
   input  logic                         AddSub,
   input  logic [NIBBLE_W*NIBBLES-1:0]  A,
   input  logic [NIBBLE_W*NIBBLES-1:0]  B,
   output logic                         Busy,
   output logic                         Done,
   output logic [NIBBLE_W*NIBBLES-1:0]  Result,
   output logic                         Cout,
   output logic                         OVR,
   output logic                         Zero
);

   localparam int W     = NIBBLE_W * NIBBLES;
   localparam int IDX_W = $clog2(NIBBLES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   logic [1:0]          state;
   logic [IDX_W-1:0]    idx;
   logic [W-1:0]        a_q;
   logic [W-1:0]        b_q;
   logic                sub_q;
   logic                carry_q;

   logic [NIBBLE_W-1:0] stage_s;
   logic                stage_c3;
   logic                stage_c4;
   logic [W-1:0]        result_next;

   nibble_addsub_stage u_stage (
      .a   (a_q[int'(idx)*NIBBLE_W +: NIBBLE_W]),
      .b   (b_q[int'(idx)*NIBBLE_W +: NIBBLE_W]),
      .sub (sub_q),
      .cin (carry_q),
      .s   (stage_s),
      .c3  (stage_c3),
      .c4  (stage_c4)
   );

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      result_next = Result;
      result_next[int'(idx)*NIBBLE_W +: NIBBLE_W] = stage_s;
   end

   assign Busy = (state != ST_IDLE);
   assign Done = (state == ST_DONE);

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state   <= ST_IDLE;
         idx     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sub_q   <= OP_ADD;
         carry_q <= 1'b0;
         Result  <= '0;
         Cout    <= 1'b0;
         OVR     <= 1'b0;
         Zero    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (Start) begin
                  a_q     <= A;
                  b_q     <= B;
                  sub_q   <= AddSub;
                  carry_q <= AddSub;
                  idx     <= '0;
                  Cout    <= 1'b0;
                  OVR     <= 1'b0;
                  Zero    <= 1'b0;
                  state   <= ST_RUN;
               end
            end
            ST_RUN: begin
               Result  <= result_next;
               carry_q <= stage_c4;
               if (idx == LAST_IDX) begin
                  // Zero is taken from the completed word so it is valid with Done.
                  Cout  <= stage_c4;
                  OVR   <= stage_c3 ^ stage_c4;
                  Zero  <= (result_next == '0);
                  state <= ST_DONE;
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
